// File: rtl/spi_slave_engine.sv
// SPI mode-0 slave engine: oversamples sclk/cs_n/mosi in clk_c, deserializes rx words, serializes tx words.
// Optional macro SPI_SLAVE_LSB_FIRST_EN switches both shift registers to LSB-first order.
module spi_slave_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_c,
    input  logic                  reset_r,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic sclk_meta, sclk_sync, sclk_hist;
    logic cs_meta, cs_sync, cs_hist;
    logic mosi_meta, mosi_sync, mosi_hist;

    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] shreg_tx;
    logic [DATA_WIDTH-1:0] shreg_rx;
    logic [CNT_W-1:0]      bit_cnt;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic load_tx, clr_cnt, shift_rx, shift_tx, capture, abort;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic                  miso_bit;

    // cs_n synchronizer resets to the deasserted level so reset never fakes a select edge
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_hist <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_hist   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            mosi_hist <= 1'b0;
        end else begin
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_hist <= sclk_sync;
            cs_meta   <= cs_n;
            cs_sync   <= cs_meta;
            cs_hist   <= cs_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
            mosi_hist <= mosi_sync;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_hist;
    assign sclk_fall = ~sclk_sync & sclk_hist;
    assign cs_rise   = cs_sync & ~cs_hist;
    assign cs_fall   = ~cs_sync & cs_hist;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next    = {mosi_hist, shreg_rx[DATA_WIDTH-1:1]};
    assign tx_shifted = {1'b0, shreg_tx[DATA_WIDTH-1:1]};
    assign miso_bit   = shreg_tx[0];
`else
    assign rx_next    = {shreg_rx[DATA_WIDTH-2:0], mosi_hist};
    assign tx_shifted = {shreg_tx[DATA_WIDTH-2:0], 1'b0};
    assign miso_bit   = shreg_tx[DATA_WIDTH-1];
`endif

    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A completing sclk rise wins over a coincident cs_n rise so the word still finishes
    always_comb begin
        state_next = state;
        load_tx    = 1'b0;
        clr_cnt    = 1'b0;
        shift_rx   = 1'b0;
        shift_tx   = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    load_tx    = 1'b1;
                    clr_cnt    = 1'b1;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_rx = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else if (cs_rise) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                    end
                end else if (cs_rise) begin
                    abort      = (bit_cnt != '0);
                    state_next = IDLE;
                end else if (sclk_fall && (bit_cnt != '0)) begin
                    shift_tx = 1'b1;
                end
            end
            DONE: begin
                if (!cs_sync) begin
                    state_next = SHIFT;
                    load_tx    = 1'b1;
                    clr_cnt    = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word captured on the completing rise so rx_data is already valid during DONE
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            tx_buf    <= '0;
            shreg_tx  <= '0;
            shreg_rx  <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_buf <= tx_data;
            end
            if (load_tx) begin
                shreg_tx <= tx_buf;
            end else if (shift_tx) begin
                shreg_tx <= tx_shifted;
            end
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (shift_rx) begin
                bit_cnt  <= bit_cnt + 1'b1;
                shreg_rx <= rx_next;
            end
            if (capture) begin
                rx_data <= rx_next;
            end
            frame_err <= abort;
        end
    end

    assign miso     = (state != IDLE) & miso_bit;
    assign rx_valid = (state == DONE);
    assign busy     = (state != IDLE);

endmodule
